// File: rtl/flash_frame_scheduler_if.sv
// Flash command, pixel progress and config-apply signals of flash_frame_scheduler.
// The master drives commands and pixel progress; the slave is the scheduler.
interface flash_frame_scheduler_if #(
  parameter int DATA_WIDTH = 384
);
  logic                  flash_wen;
  logic [7:0]            flash_cmd;
  logic [DATA_WIDTH-1:0] flash_data;
  logic                  flash_ready;
  logic [10:0]           pixel_h;
  logic [9:0]            pixel_v;
  logic                  ray_done;
  logic                  force_overwrite;
  logic                  rtx_hold;
  logic                  apply_wen;
  logic [7:0]            apply_cmd;
  logic [DATA_WIDTH-1:0] apply_data;
  logic                  rtx_overwrite;
  logic [7:0]            drop_count;
  logic                  busy;

  modport master (
    output flash_wen, flash_cmd, flash_data, pixel_h, pixel_v, ray_done, force_overwrite,
    input  flash_ready, rtx_hold, apply_wen, apply_cmd, apply_data, rtx_overwrite,
           drop_count, busy
  );

  modport slave (
    input  flash_wen, flash_cmd, flash_data, pixel_h, pixel_v, ray_done, force_overwrite,
    output flash_ready, rtx_hold, apply_wen, apply_cmd, apply_data, rtx_overwrite,
           drop_count, busy
  );
endinterface

// File: rtl/flash_frame_scheduler.sv
// Queues flash commands and applies them at frame end while holding rtx; optional FLASH_SCHED_CAM_BYPASS_EN.
// Latency: first apply_wen two cycles after the frame-end cycle, one per cycle after that.
// Backpressure: flash_ready low when the FIFO is full; commands offered while full are dropped and counted.
module flash_frame_scheduler #(
  parameter int DATA_WIDTH = 384,
  parameter int FIFO_DEPTH = 8,
  parameter int H_LAST     = 1279,
  parameter int V_LAST     = 719
) (
  input logic                   clk,
  input logic                   rst,
  flash_frame_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 8 + DATA_WIDTH;

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d, drain_left_q, drain_left_d;
  logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
  logic                  ready_q, ready_d, hold_q, hold_d, wen_q, wen_d;
  logic                  ovw_q, ovw_d, pend_q, pend_d;
  logic [7:0]            cmd_q, cmd_d, drop_q, drop_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  frame_end, full, bypass, push, pop;

  assign frame_end = bus.ray_done && (bus.pixel_h == 11'(H_LAST)) && (bus.pixel_v == 10'(V_LAST));
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));

`ifdef FLASH_SCHED_CAM_BYPASS_EN
  // Camera opcodes 0x00-0x03 skip the queue and pre-empt a drain pop.
  assign bypass = bus.flash_wen && (bus.flash_cmd[7:2] == 6'd0);
`else
  assign bypass = 1'b0;
`endif

  assign push = bus.flash_wen && !bypass && !full;
  assign pop  = (state_q == DRAIN) && !bypass;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    drain_left_d = drain_left_q;
    ovw_d        = ovw_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    drop_d       = drop_q;
    wen_d        = bypass || pop;
    pend_d       = bypass || (pend_q && !((state_q == IDLE) && frame_end));

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (bus.flash_wen && !bypass && full && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    if (bypass) begin
      cmd_d  = bus.flash_cmd;
      data_d = bus.flash_data;
    end else if (pop) begin
      {cmd_d, data_d} = mem_q[rd_ptr_q];
    end

    case (state_q)
      IDLE: begin
        // Snapshot uses count_q so a push in the frame-end cycle waits a frame.
        if (frame_end) begin
          ovw_d = bus.force_overwrite || (count_q != '0) || pend_q;
          if (count_q != '0) begin
            state_d      = DRAIN;
            drain_left_d = count_q;
          end
        end
      end
      DRAIN: begin
        if (pop) begin
          drain_left_d = drain_left_q - CNT_W'(1);
          if (drain_left_q == CNT_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    hold_d  = (state_d == DRAIN) || pop;
    ready_d = (count_d != CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drain_left_q <= '0;
      ready_q      <= 1'b0;
      hold_q       <= 1'b0;
      wen_q        <= 1'b0;
      ovw_q        <= 1'b0;
      pend_q       <= 1'b0;
      cmd_q        <= '0;
      drop_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drain_left_q <= drain_left_d;
      ready_q      <= ready_d;
      hold_q       <= hold_d;
      wen_q        <= wen_d;
      ovw_q        <= ovw_d;
      pend_q       <= pend_d;
      cmd_q        <= cmd_d;
      drop_q       <= drop_d;
      data_q       <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.flash_cmd, bus.flash_data};
  end

  assign bus.flash_ready   = ready_q;
  assign bus.rtx_hold      = hold_q;
  assign bus.apply_wen     = wen_q;
  assign bus.apply_cmd     = cmd_q;
  assign bus.apply_data    = data_q;
  assign bus.rtx_overwrite = ovw_q;
  assign bus.drop_count    = drop_q;
  assign bus.busy          = (state_q == DRAIN);
endmodule
